// File: rtl/vga_text_capture_pkg.sv
// ----------------------------------------------------------------------------
// vga_text_pkg
// Shared constants for the VGA text capture block: character cell geometry,
// default 640x480 VGA timing, port field widths and the emitter state type.
// ----------------------------------------------------------------------------
package vga_text_pkg;

   // Character cell: 5x9 pitch, of which the top-left 4x8 carries glyph pixels
   localparam int unsigned CELL_W  = 5;
   localparam int unsigned CELL_H  = 9;
   localparam int unsigned GLYPH_W = 4;
   localparam int unsigned GLYPH_H = 8;
   localparam int unsigned SIG_W   = GLYPH_W * GLYPH_H;

   // Default VGA 640x480@60 timing
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FRONT  = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BACK   = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FRONT  = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BACK   = 33;

   // Field widths
   localparam int unsigned POS_W = 12;  // signed position counters
   localparam int unsigned COL_W = 5;
   localparam int unsigned ROW_W = 6;
   localparam int unsigned GX_W  = 2;   // in-glyph x, 0..3
   localparam int unsigned GY_W  = 3;   // in-glyph y, 0..7

   typedef enum logic {
      E_IDLE,
      E_SEND
   } emit_state_t;

endpackage

// File: rtl/vga_text_capture_pos_recover.sv
// ----------------------------------------------------------------------------
// vga_pos_recover
// Recovers pixel position from registered hsync/vsync edges and maps it onto
// character cells.
//   clk, rst_n          : pixel clock, async active-low reset
//   i_hsync, i_vsync    : raw sync from the renderer
//   i_video             : raw pixel value
//   o_capture_en        : current registered sample is a glyph pixel to store
//   o_video             : registered pixel value
//   o_col, o_xx         : cell column and in-glyph x of the registered sample
//   o_row, o_yy         : text row and in-glyph y of the registered sample
//   o_locked            : set by the first vsync end, cleared only by reset
// ----------------------------------------------------------------------------
module vga_pos_recover
   import vga_text_pkg::*;
#(
   parameter int H_BACK          = VGA_H_BACK,
   parameter int V_BACK          = VGA_V_BACK,
   parameter int H_ACTIVE        = VGA_H_ACTIVE,
   parameter int V_ACTIVE        = VGA_V_ACTIVE,
   parameter int COLS            = 32,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_hsync,
   input  logic             i_vsync,
   input  logic             i_video,
   output logic             o_capture_en,
   output logic             o_video,
   output logic [COL_W-1:0] o_col,
   output logic [GX_W-1:0]  o_xx,
   output logic [ROW_W-1:0] o_row,
   output logic [GY_W-1:0]  o_yy,
   output logic             o_locked
);

   localparam int ROWS = V_ACTIVE / int'(CELL_H);

   localparam logic signed [POS_W-1:0] S_ZERO  = POS_W'(0);
   localparam logic signed [POS_W-1:0] S_ONE   = POS_W'(1);
   localparam logic signed [POS_W-1:0] X_START = POS_W'(-H_BACK);
   localparam logic signed [POS_W-1:0] Y_START = POS_W'(-V_BACK);
   localparam logic signed [POS_W-1:0] X_END   = POS_W'(H_ACTIVE);
   localparam logic signed [POS_W-1:0] Y_END   = POS_W'(V_ACTIVE);

   // Input register, syncs normalised to "active" flags
   logic r_hs_act, r_vs_act, r_video;
   logic r_hs_act_d, r_vs_act_d;

   // Counter state describes the previous registered sample
   logic signed [POS_W-1:0] r_x, r_line;
   logic [2:0]              r_xx;
   logic [3:0]              r_yy;
   logic [POS_W-1:0]        r_col, r_row;
   logic                    r_locked;

   // Position of the current registered sample
   logic                    w_h_end, w_v_end;
   logic signed [POS_W-1:0] w_x, w_line;
   logic [2:0]              w_xx;
   logic [3:0]              w_yy;
   logic [POS_W-1:0]        w_col, w_row;
   logic                    w_cap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs_act   <= 1'b0;
         r_vs_act   <= 1'b0;
         r_video    <= 1'b0;
         r_hs_act_d <= 1'b0;
         r_vs_act_d <= 1'b0;
      end else begin
         r_hs_act   <= SYNC_ACTIVE_LOW ? ~i_hsync : i_hsync;
         r_vs_act   <= SYNC_ACTIVE_LOW ? ~i_vsync : i_vsync;
         r_video    <= i_video;
         r_hs_act_d <= r_hs_act;
         r_vs_act_d <= r_vs_act;
      end
   end

   assign w_h_end = r_hs_act_d & ~r_hs_act;
   assign w_v_end = r_vs_act_d & ~r_vs_act;

   // Counters are resolved combinationally for the sample now in the input
   // register, so the capture decision lands one clock after sampling.
   always_comb begin
      w_x  = w_h_end ? X_START : r_x + S_ONE;
      w_xx = r_xx;
      w_col = r_col;
      if (w_x <= S_ZERO) begin
         w_xx  = '0;
         w_col = '0;
      end else if (r_xx == 3'(CELL_W - 1)) begin
         w_xx  = '0;
         w_col = r_col + 1'b1;
      end else begin
         w_xx = r_xx + 1'b1;
      end
   end

   always_comb begin
      w_line = r_line;
      if (w_v_end) begin
         w_line = Y_START;
      end else if (w_h_end) begin
         w_line = r_line + S_ONE;
      end
      w_yy  = r_yy;
      w_row = r_row;
      if (w_line <= S_ZERO) begin
         w_yy  = '0;
         w_row = '0;
      end else if (w_h_end) begin
         if (r_yy == 4'(CELL_H - 1)) begin
            w_yy  = '0;
            w_row = r_row + 1'b1;
         end else begin
            w_yy = r_yy + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_x      <= '0;
         r_line   <= '0;
         r_xx     <= '0;
         r_yy     <= '0;
         r_col    <= '0;
         r_row    <= '0;
         r_locked <= 1'b0;
      end else begin
         r_x      <= w_x;
         r_line   <= w_line;
         r_xx     <= w_xx;
         r_yy     <= w_yy;
         r_col    <= w_col;
         r_row    <= w_row;
         r_locked <= r_locked | w_v_end;
      end
   end

   assign w_cap = r_locked
                & (w_x >= S_ZERO) & (w_x < X_END)
                & (w_line >= S_ZERO) & (w_line < Y_END)
                & (w_xx < 3'(GLYPH_W)) & (w_yy < 4'(GLYPH_H))
                & (w_col < POS_W'(COLS)) & (w_row < POS_W'(ROWS));

   assign o_capture_en = w_cap;
   assign o_video      = r_video;
   assign o_col        = w_col[COL_W-1:0];
   assign o_xx         = w_xx[GX_W-1:0];
   assign o_row        = w_row[ROW_W-1:0];
   assign o_yy         = w_yy[GY_W-1:0];
   assign o_locked     = r_locked;

endmodule

// File: rtl/vga_text_capture.sv
// ----------------------------------------------------------------------------
// vga_text_capture
// Captures the renderer's 1-bit video into a per-column glyph buffer and
// streams one 32-bit signature per character cell once a text row completes.
//   clk, rst_n               : pixel clock, async active-low reset
//   hsync, vsync, video      : renderer outputs
//   cell_valid / cell_ready  : signature stream handshake
//   cell_col, cell_row       : cell coordinates of the current beat
//   cell_bits                : signature, bit 4*yy+xx = glyph pixel (xx,yy)
//   locked                   : position counters valid
//   overrun                  : sticky, a row was abandoned before draining
// ----------------------------------------------------------------------------
module vga_text_capture
   import vga_text_pkg::*;
#(
   parameter int H_BACK          = VGA_H_BACK,
   parameter int V_BACK          = VGA_V_BACK,
   parameter int H_ACTIVE        = VGA_H_ACTIVE,
   parameter int V_ACTIVE        = VGA_V_ACTIVE,
   parameter int COLS            = 32,
   parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             hsync,
   input  logic             vsync,
   input  logic             video,
   output logic             cell_valid,
   input  logic             cell_ready,
   output logic [COL_W-1:0] cell_col,
   output logic [ROW_W-1:0] cell_row,
   output logic [SIG_W-1:0] cell_bits,
   output logic             locked,
   overrun
);

   logic             w_cap, w_video;
   logic [COL_W-1:0] w_col;
   logic [GX_W-1:0]  w_xx;
   logic [ROW_W-1:0] w_row;
   logic [GY_W-1:0]  w_yy;
   logic [4:0]       w_idx;
   logic             w_first, w_last;

   logic [SIG_W-1:0] r_buf [COLS];

   emit_state_t      r_state, w_state_nx;
   logic [COL_W-1:0] r_k, w_k_nx;
   logic [ROW_W-1:0] r_row, w_row_nx;
   logic             r_overrun, w_overrun_nx;
   logic             w_accept;

   vga_pos_recover #(
      .H_BACK          (H_BACK),
      .V_BACK          (V_BACK),
      .H_ACTIVE        (H_ACTIVE),
      .V_ACTIVE        (V_ACTIVE),
      .COLS            (COLS),
      .SYNC_ACTIVE_LOW (SYNC_ACTIVE_LOW)
   ) u_pos (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_hsync      (hsync),
      .i_vsync      (vsync),
      .i_video      (video),
      .o_capture_en (w_cap),
      .o_video      (w_video),
      .o_col        (w_col),
      .o_xx         (w_xx),
      .o_row        (w_row),
      .o_yy         (w_yy),
      .o_locked     (locked)
   );

   // With a 4-wide glyph, {yy, xx} is exactly 4*yy + xx
   assign w_idx = {w_yy, w_xx};

   assign w_first = w_cap & (w_col == '0) & (w_xx == '0) & (w_yy == '0);
   assign w_last  = w_cap & (w_col == COL_W'(COLS - 1))
                  & (w_xx == GX_W'(GLYPH_W - 1)) & (w_yy == GY_W'(GLYPH_H - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned c = 0; c < COLS; c++) begin
            r_buf[c] <= '0;
         end
      end else if (w_cap) begin
         for (int unsigned c = 0; c < COLS; c++) begin
            if (w_col == COL_W'(c)) begin
               r_buf[c][w_idx] <= w_video;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= E_IDLE;
         r_k       <= '0;
         r_row     <= '0;
         r_overrun <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_k       <= w_k_nx;
         r_row     <= w_row_nx;
         r_overrun <= w_overrun_nx;
      end
   end

   assign w_accept = (r_state == E_SEND) & cell_ready;

   always_comb begin
      w_state_nx   = r_state;
      w_k_nx       = r_k;
      w_row_nx     = r_row;
      w_overrun_nx = r_overrun;
      case (r_state)
         E_IDLE: begin
            if (w_last) begin
               w_state_nx = E_SEND;
               w_k_nx     = '0;
               w_row_nx   = w_row;
            end
         end
         E_SEND: begin
            if (w_accept) begin
               w_k_nx = r_k + 1'b1;
            end
            // A beat accepted together with the abort still counts; only
            // beats left over make it an overrun.
            if (w_accept && (r_k == COL_W'(COLS - 1))) begin
               w_state_nx = E_IDLE;
               w_k_nx     = '0;
            end else if (w_first) begin
               w_state_nx   = E_IDLE;
               w_overrun_nx = 1'b1;
            end
         end
         default: w_state_nx = E_IDLE;
      endcase
   end

   assign cell_valid = (r_state == E_SEND);
   assign cell_col   = r_k;
   assign cell_row   = r_row;
   assign cell_bits  = cell_valid ? r_buf[r_k] : '0;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_vga_text_capture.sv
module tb_vga_text_capture;
   import vga_text_pkg::*;

   // Reduced timing keeps the run short; same structure as 640x480
   localparam int H_ACT = 170, H_FP = 4, H_SY = 8, H_BP = 6;
   localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
   localparam int V_ACT = 20, V_FP = 2, V_SY = 2, V_BP = 3;
   localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
   localparam int NCOLS = 32;
   localparam int NROWS = V_ACT / 9;
   localparam int BUDGET = 2 * H_TOT * V_TOT;

   localparam logic [31:0] GLYPH [0:9] = '{
      32'h69999996, 32'h72222232, 32'hF1124896, 32'h69886896, 32'h888F9AC8,
      32'h6988711F, 32'h69997116, 32'h2224488F, 32'h69996996, 32'h688E9996};

   logic        clk = 1'b0;
   logic        rst_n, hsync, vsync, video, cell_ready;
   logic        cell_valid, locked, overrun;
   logic [4:0]  cell_col;
   logic [5:0]  cell_row;
   logic [31:0] cell_bits;

   typedef struct {
      int          row;
      int          col;
      logic [31:0] bits;
   } cell_t;

   cell_t sb[$];
   int n_vec = 0, n_miss = 0, n_beats = 0;
   int mode = 0, rmode = 0, sb_en = 0, skip_row0 = 0, rcnt = 0;
   int gh = 0, gv = 5;

   always #5 clk = ~clk;

   vga_text_capture #(
      .H_BACK          (H_BP),
      .V_BACK          (V_BP),
      .H_ACTIVE        (H_ACT),
      .V_ACTIVE        (V_ACT),
      .COLS            (NCOLS),
      .SYNC_ACTIVE_LOW (1'b1)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .hsync      (hsync),
      .vsync      (vsync),
      .video      (video),
      .cell_valid (cell_valid),
      .cell_ready (cell_ready),
      .cell_col   (cell_col),
      .cell_row   (cell_row),
      .cell_bits  (cell_bits),
      .locked     (locked),
      .overrun    (overrun)
   );

   // Pixel pattern per mode: 0 black, 1 white, 2 two single pixels,
   // 3 gap pixels only, 4 digit text, other: pseudo-random
   function automatic logic pix(input int m, input int x, input int y);
      logic [31:0] g;
      int unsigned h;
      if (x < 0 || x >= H_ACT || y < 0 || y >= V_ACT) return 1'b0;
      case (m)
         0: return 1'b0;
         1: return 1'b1;
         2: return (x == 5 && y == 0) || (x == 3 && y == 7);
         3: return (x % 5 == 4) || (y % 9 == 8);
         4: begin
            if (x % 5 < 4 && y % 9 < 8) begin
               g = GLYPH[(x / 5) % 10];
               return g[4 * (y % 9) + (x % 5)];
            end
            return 1'b0;
         end
         default: begin
            h = (x * 32'h9E3779B1) ^ (y * 32'h85EBCA77);
            h = h ^ (h >> 15);
            return h[7];
         end
      endcase
   endfunction

   function automatic logic [31:0] exp_sig(input int m, input int col, input int row);
      logic [31:0] s;
      s = '0;
      for (int yy = 0; yy < 8; yy++)
         for (int xx = 0; xx < 4; xx++)
            s[4 * yy + xx] = pix(m, 5 * col + xx, 9 * row + yy);
      return s;
   endfunction

   // Renderer model + consumer + scoreboard, all on the falling edge
   initial begin : gen_mon
      cell_t e;
      hsync = 1'b1; vsync = 1'b1; video = 1'b0; cell_ready = 1'b0;
      forever begin
         @(negedge clk);
         case (rmode)
            0: cell_ready = 1'b1;
            1: cell_ready = (rcnt == 0);
            default: cell_ready = 1'b0;
         endcase
         rcnt = (rcnt == 2) ? 0 : rcnt + 1;
         if (cell_valid && cell_ready) begin
            n_beats++;
            n_vec++;
            if (sb.size() == 0) begin
               n_miss++;
               $display("FAIL beat_unexpected: got row %0d col %0d bits %h, required no beat",
                        cell_row, cell_col, cell_bits);
            end else begin
               e = sb.pop_front();
               if ({cell_row, cell_col, cell_bits} !== {6'(e.row), 5'(e.col), e.bits}) begin
                  n_miss++;
                  $display("FAIL beat: got row %0d col %0d bits %h, required row %0d col %0d bits %h",
                           cell_row, cell_col, cell_bits, e.row, e.col, e.bits);
               end
            end
         end
         if (gh == H_TOT - 1) begin
            gh = 0;
            gv = (gv == V_TOT - 1) ? 0 : gv + 1;
         end else begin
            gh++;
         end
         hsync = !(gh >= H_ACT + H_FP && gh < H_ACT + H_FP + H_SY);
         vsync = !(gv >= V_ACT + V_FP && gv < V_ACT + V_FP + V_SY);
         video = pix(mode, gh, gv);
         if (gh == 0 && gv % 9 == 0 && gv / 9 < NROWS && sb_en != 0 &&
             !(gv == 0 && skip_row0 != 0)) begin
            for (int c = 0; c < NCOLS; c++) begin
               e.row = gv / 9;
               e.col = c;
               e.bits = exp_sig(mode, c, gv / 9);
               sb.push_back(e);
            end
         end
      end
   end

   // Waits until the pixel at (h, v) has just been sampled by the DUT
   task automatic wait_pos(input int v, input int h);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(gv == v && gh == h) && n < BUDGET);
      if (!(gv == v && gh == h)) begin
         n_vec++;
         n_miss++;
         $display("FAIL wait_pos: reached line %0d x %0d, required line %0d x %0d", gv, gh, v, h);
      end
   endtask

   // Runs from blanking to the same point in the next frame
   task automatic run_frame(input int m, input int r, input string name);
      int b0;
      mode = m;
      rmode = r;
      sb_en = 1;
      b0 = n_beats;
      wait_pos(V_ACT + 1, 0);
      n_vec++;
      if (n_beats - b0 !== NROWS * NCOLS) begin
         n_miss++;
         $display("FAIL %s_count: got %0d beats, required %0d", name, n_beats - b0, NROWS * NCOLS);
      end
      n_vec++;
      if (sb.size() !== 0) begin
         n_miss++;
         $display("FAIL %s_drain: got %0d pending, required 0", name, sb.size());
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if ({cell_valid, locked, overrun} !== 3'b000) begin
         n_miss++;
         $display("FAIL reset_flags: got valid/locked/overrun %b, required 000",
                  {cell_valid, locked, overrun});
      end
      n_vec++;
      if ({cell_row, cell_col, cell_bits} !== 43'd0) begin
         n_miss++;
         $display("FAIL reset_fields: got row %0d col %0d bits %h, required 0", cell_row, cell_col, cell_bits);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_lock;
      wait_pos(V_ACT + V_FP + V_SY, 0);
      n_vec++;
      if (locked !== 1'b0) begin
         n_miss++;
         $display("FAIL lock_before: got %b, required 0", locked);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (locked !== 1'b1) begin
         n_miss++;
         $display("FAIL lock_after: got %b, required 1", locked);
      end
   endtask

   task automatic test_single_latency;
      int b0;
      mode = 2;
      rmode = 0;
      b0 = n_beats;
      wait_pos(7, 5 * NCOLS - 2);
      n_vec++;
      if (cell_valid !== 1'b0) begin
         n_miss++;
         $display("FAIL latency_early: got valid %b, required 0", cell_valid);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({cell_valid, cell_row, cell_col, cell_bits} !== {1'b1, 6'd0, 5'd0, exp_sig(2, 0, 0)}) begin
         n_miss++;
         $display("FAIL latency_first: got valid %b row %0d col %0d bits %h, required 1 0 0 %h",
                  cell_valid, cell_row, cell_col, cell_bits, exp_sig(2, 0, 0));
      end
      wait_pos(V_ACT + 1, 0);
      n_vec++;
      if (n_beats - b0 !== NROWS * NCOLS || sb.size() !== 0) begin
         n_miss++;
         $display("FAIL single_count: got %0d beats %0d pending, required %0d beats 0 pending",
                  n_beats - b0, sb.size(), NROWS * NCOLS);
      end
   endtask

   task automatic test_overrun;
      int b0;
      mode = 4;
      rmode = 2;
      skip_row0 = 1;
      b0 = n_beats;
      wait_pos(8, 100);
      n_vec++;
      if ({cell_valid, cell_col, cell_row, overrun} !== {1'b1, 5'd0, 6'd0, 1'b0}) begin
         n_miss++;
         $display("FAIL overrun_hold: got valid %b col %0d row %0d overrun %b, required 1 0 0 0",
                  cell_valid, cell_col, cell_row, overrun);
      end
      n_vec++;
      if (cell_bits !== exp_sig(4, 0, 0)) begin
         n_miss++;
         $display("FAIL overrun_hold_bits: got %h, required %h", cell_bits, exp_sig(4, 0, 0));
      end
      wait_pos(9, 0);
      n_vec++;
      if (overrun !== 1'b0) begin
         n_miss++;
         $display("FAIL overrun_early: got %b, required 0", overrun);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if ({overrun, cell_valid} !== 2'b10) begin
         n_miss++;
         $display("FAIL overrun_abort: got overrun/valid %b, required 10", {overrun, cell_valid});
      end
      rmode = 0;
      skip_row0 = 0;
      wait_pos(V_ACT + 1, 0);
      n_vec++;
      if (n_beats - b0 !== NCOLS || sb.size() !== 0 || overrun !== 1'b1) begin
         n_miss++;
         $display("FAIL overrun_row1: got %0d beats %0d pending overrun %b, required %0d 0 1",
                  n_beats - b0, sb.size(), overrun, NCOLS);
      end
   endtask

   task automatic test_reset_mid_send;
      int b0;
      mode = 4;
      rmode = 1;
      wait_pos(8, 40);
      n_vec++;
      if (cell_valid !== 1'b1) begin
         n_miss++;
         $display("FAIL midsend_valid: got %b, required 1", cell_valid);
      end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if ({cell_valid, locked, overrun, cell_col, cell_row, cell_bits} !== 46'd0) begin
         n_miss++;
         $display("FAIL midsend_reset: got valid %b locked %b overrun %b col %0d row %0d bits %h, required all 0",
                  cell_valid, locked, overrun, cell_col, cell_row, cell_bits);
      end
      sb.delete();
      sb_en = 0;
      b0 = n_beats;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      test_lock();
      n_vec++;
      if (n_beats !== b0) begin
         n_miss++;
         $display("FAIL midsend_quiet: got %0d beats while unlocked, required 0", n_beats - b0);
      end
   endtask

   initial begin : tests
      test_reset();
      test_lock();
      run_frame(0, 0, "zero");
      test_single_latency();
      run_frame(1, 0, "ones");
      run_frame(3, 0, "gaps");
      run_frame(4, 0, "text");
      run_frame(5, 1, "backpressure");
      n_vec++;
      if (overrun !== 1'b0) begin
         n_miss++;
         $display("FAIL backpressure_overrun: got %b, required 0", overrun);
      end
      test_overrun();
      test_reset_mid_send();
      run_frame(4, 0, "relock");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
